// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width default and skid-buffer occupancy encoding for the async FIFO read path
package fifo_pkg;
  localparam int DEF_FIFO_WIDTH = 16;
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;
endpackage

// File: rtl/fifo_drain_skid2.sv
// fifo_drain_skid2: 2-entry in-order buffer between FIFO pops and a valid/ready stream
module fifo_drain_skid2
  import fifo_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         m_valid,
  output logic         full,
  output logic [W-1:0] m_data
);
  state_t state_q, state_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      S_EMPTY: if (push) begin
        state_d = S_ONE;
        head_d  = din;
      end
      S_ONE: if (push && pop) head_d = din;
        else if (push) begin
          state_d = S_TWO;
          tail_d  = din;
        end else if (pop) state_d = S_EMPTY;
      S_TWO: if (pop) begin
        state_d = S_ONE;
        head_d  = tail_q;
      end
      default: state_d = S_EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
  assign m_valid = state_q != S_EMPTY;
  assign full    = state_q == S_TWO;
  assign m_data  = head_q;
endmodule

// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer: pops the async FIFO read side and re-emits words as burst-framed valid/ready beats
module fifo_read_drainer
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);
  localparam int PW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(BURST_LEN - 1);
  logic full, pop;
  logic [PW-1:0] pos_q, pos_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  // pop request sees only registered occupancy, so a full buffer never pushes even while draining
  assign fifo_rd_en = !rst && enable && !fifo_empty && !full;
  assign pop        = m_valid && m_ready;
  assign m_last     = m_valid && pos_q == POS_MAX;
  assign beat_cnt   = beat_cnt_q;
  fifo_drain_skid2 #(.W(FIFO_WIDTH)) u_skid (
    .clk    (rd_clk),
    .rst    (rst),
    .push   (fifo_rd_en),
    .pop    (pop),
    .din    (fifo_dout),
    .m_valid(m_valid),
    .full   (full),
    .m_data (m_data)
  );
  always_comb begin
    pos_d      = pop ? (pos_q == POS_MAX ? '0 : pos_q + PW'(1)) : pos_q;
    beat_cnt_d = beat_cnt_q + CNT_WIDTH'(pop);
  end
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      pos_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      pos_q      <= pos_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_read_drainer.sv
// tb_fifo_read_drainer: queue-based FIFO source and reference model, table vectors plus random traffic
module tb_fifo_read_drainer;
  localparam int W = 16, BL = 4, CW = 16;
  logic rd_clk = 0, rst = 1, enable = 1, fifo_empty = 1, m_ready = 1;
  logic [W-1:0] fifo_dout = '0;
  logic fifo_rd_en, m_valid, m_last;
  logic [W-1:0] m_data;
  logic [CW-1:0] beat_cnt;
  always #5 rd_clk = ~rd_clk;
  fifo_read_drainer #(.FIFO_WIDTH(W), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .rd_clk(rd_clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .beat_cnt(beat_cnt)
  );
  typedef struct {
    logic en; logic rdy; logic ev; logic [W-1:0] ed; logic el; logic [CW-1:0] ec;
  } vec_t;
  vec_t tbl[10];
  int n_vec = 0, n_bad = 0, beats = 0, tbl_i = 0;
  bit armed = 0, zflag = 1, tbl_on = 0;
  logic [W-1:0] src_q[$], mbuf[$];
  logic [W-1:0] next_word = 16'd1;
  logic [CW-1:0] b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic refresh();
    fifo_empty = src_q.size() == 0;
    fifo_dout  = src_q.size() > 0 ? src_q[0] : '0;
  endtask
  task automatic load(input int n);
    repeat (n) begin
      src_q.push_back(next_word);
      next_word++;
    end
    refresh();
  endtask
  task automatic cycle();
    logic exp_rd, acc, rd;
    logic [W-1:0] w, junk;
    @(negedge rd_clk);
    exp_rd = !rst && enable && !fifo_empty && mbuf.size() < 2;
    chk("fifo_rd_en", fifo_rd_en, exp_rd);
    if (armed) begin
      chk("m_valid", m_valid, mbuf.size() > 0);
      if (mbuf.size() > 0) chk("m_data", m_data, mbuf[0]);
      else if (zflag) chk("m_data_rst", m_data, 0);
      chk("m_last", m_last, mbuf.size() > 0 && beats % BL == BL - 1);
      chk("beat_cnt", beat_cnt, beats & 32'hffff);
    end
    if (tbl_on) begin
      chk("tbl_valid", m_valid, tbl[tbl_i].ev);
      if (tbl[tbl_i].ev) chk("tbl_data", m_data, tbl[tbl_i].ed);
      chk("tbl_last", m_last, tbl[tbl_i].el);
      chk("tbl_cnt", beat_cnt, tbl[tbl_i].ec);
    end
    acc = m_ready && mbuf.size() > 0;
    rd  = fifo_rd_en;
    w   = fifo_dout;
    @(posedge rd_clk);
    #1;
    if (rd && src_q.size() > 0) junk = src_q.pop_front();
    if (rst) begin
      mbuf.delete();
      beats = 0;
      zflag = 1;
      armed = 1;
    end else begin
      if (acc) begin
        junk = mbuf.pop_front();
        beats++;
      end
      if (exp_rd) begin
        mbuf.push_back(w);
        zflag = 0;
      end
    end
    refresh();
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 16'd1, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 16'd1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 16'd3, 1'b0, 16'd2};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 16'd3};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 16'd5, 1'b0, 16'd4};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 16'd6, 1'b0, 16'd5};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 16'd7, 1'b0, 16'd6};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 16'd8, 1'b1, 16'd7};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 16'd8};
    rst = 1;
    load(8);
    repeat (3) cycle();
    rst = 0;
    tbl_on = 1;
    for (int i = 0; i < 10; i++) begin
      enable  = tbl[i].en;
      m_ready = tbl[i].rdy;
      tbl_i   = i;
      cycle();
    end
    tbl_on = 0;
    load(12);
    repeat (3) cycle();
    m_ready = 0;
    repeat (5) cycle();
    m_ready = 1;
    repeat (14) cycle();
    load(8);
    repeat (3) cycle();
    enable = 0;
    repeat (4) cycle();
    enable = 1;
    repeat (10) cycle();
    b0 = beat_cnt;
    load(1);
    repeat (5) cycle();
    chk("one_beat", beat_cnt - b0, 1);
    load(6);
    m_ready = 0;
    repeat (3) cycle();
    rst = 1;
    cycle();
    rst = 0;
    m_ready = 1;
    repeat (8) cycle();
    repeat (400) begin
      enable  = $urandom_range(0, 3) != 0;
      m_ready = $urandom_range(0, 2) != 0;
      rst     = $urandom_range(0, 60) == 0;
      if ($urandom_range(0, 3) == 0) load($urandom_range(1, 3));
      cycle();
    end
    rst = 0;
    enable = 1;
    m_ready = 1;
    repeat (40) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
